// File: rtl/riscv_core_div_pkg.sv
// Shared types, constants and combinational helpers for the divide controller.
// Optional W-form support in the controller is selected by RISCV_DIV_CTRL_WORD_EN.
package riscv_core_div_pkg;

    localparam int unsigned DIV_XLEN = 64;

    localparam logic [DIV_XLEN-1:0] MOST_NEG = {1'b1, {(DIV_XLEN-1){1'b0}}};
    localparam logic [DIV_XLEN-1:0] ALL_ONES = {DIV_XLEN{1'b1}};

    // Encoding matches funct3[1:0] of the M-extension divide group.
    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StFix,
        StResp,
        StDrain
    } div_state_e;

    // Two's-complement negation at datapath width.
    function automatic logic [DIV_XLEN-1:0] negate(input logic [DIV_XLEN-1:0] x);
        return ~x + {{(DIV_XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Widen a 32-bit word operand, sign- or zero-extending.
    function automatic logic [DIV_XLEN-1:0] ext_word(input logic [31:0] x, input logic sgn);
        return {{(DIV_XLEN-32){sgn & x[31]}}, x};
    endfunction

    // W-form results are always sign-extended from bit 31.
    function automatic logic [DIV_XLEN-1:0] sext_word(input logic [31:0] x);
        return {{(DIV_XLEN-32){x[31]}}, x};
    endfunction

endpackage

// File: rtl/riscv_core_div_ctrl_if.sv
// Request/response bundle between execute/writeback and the divide controller.
interface riscv_core_div_ctrl_if #(
    parameter int unsigned XLEN = 64
) ();

    logic            i_div_ctrl_valid;
    logic            o_div_ctrl_ready;
    logic [1:0]      i_div_ctrl_op;
    logic            i_div_ctrl_word;
    logic [XLEN-1:0] i_div_ctrl_rs1;
    logic [XLEN-1:0] i_div_ctrl_rs2;
    logic [4:0]      i_div_ctrl_rd;
    logic            i_div_ctrl_flush;
    logic            o_div_ctrl_valid;
    logic            i_div_ctrl_ready;
    logic [XLEN-1:0] o_div_ctrl_result;
    logic [4:0]      o_div_ctrl_rd;
    logic            o_div_ctrl_busy;

    // Controller side.
    modport slave (
        input  i_div_ctrl_valid, i_div_ctrl_op, i_div_ctrl_word, i_div_ctrl_rs1,
               i_div_ctrl_rs2, i_div_ctrl_rd, i_div_ctrl_flush, i_div_ctrl_ready,
        output o_div_ctrl_ready, o_div_ctrl_valid, o_div_ctrl_result, o_div_ctrl_rd,
               o_div_ctrl_busy
    );

    // Pipeline side.
    modport master (
        output i_div_ctrl_valid, i_div_ctrl_op, i_div_ctrl_word, i_div_ctrl_rs1,
               i_div_ctrl_rs2, i_div_ctrl_rd, i_div_ctrl_flush, i_div_ctrl_ready,
        input  o_div_ctrl_ready, o_div_ctrl_valid, o_div_ctrl_result, o_div_ctrl_rd,
               o_div_ctrl_busy
    );

endinterface

// File: rtl/riscv_core_non_restoring.sv
// Unsigned non-restoring divider: XLEN iterations after a one-cycle enable,
// then a one-cycle done pulse with quotient/remainder valid in that cycle.
module riscv_core_non_restoring #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    // Partial remainder carries two extra bits so the shifted value never overflows.
    logic [XLEN+1:0] part_q, part_d, shifted;
    logic [XLEN-1:0] quo_q, quo_d, dsr_q;
    logic [CntW-1:0] cnt_q;
    logic            busy_q, done_q;

    // One iteration: add or subtract the divisor depending on the current sign.
    always_comb begin
        shifted = {part_q[XLEN:0], quo_q[XLEN-1]};
        part_d  = part_q[XLEN+1] ? shifted + {2'b00, dsr_q} : shifted - {2'b00, dsr_q};
        quo_d   = {quo_q[XLEN-2:0], ~part_d[XLEN+1]};
    end

    // Iteration state; enable loads operands, done pulses after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_q <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en) begin
                part_q <= '0;
                quo_q  <= dividend;
                dsr_q  <= divisor;
                cnt_q  <= CntW'(XLEN);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                part_q <= part_d;
                quo_q  <= quo_d;
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    // Final restore step: a negative partial remainder needs the divisor added back.
    assign remainder = part_q[XLEN+1] ? part_q[XLEN-1:0] + dsr_q : part_q[XLEN-1:0];

endmodule

// File: rtl/riscv_core_div_ctrl.sv
// Divide sequencing controller: handles div-by-zero and signed overflow directly,
// runs everything else through the unsigned core on magnitudes, then fixes signs.
// Define RISCV_DIV_CTRL_WORD_EN to support the W forms (DIVW/DIVUW/REMW/REMUW).
module riscv_core_div_ctrl
    import riscv_core_div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input logic                  i_div_ctrl_clk,
    input logic                  i_div_ctrl_rstn,
    riscv_core_div_ctrl_if.slave bus
);

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d, req_op;
    logic [4:0]      rd_q, rd_d;
    logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [XLEN-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, res_q, res_d;

    logic            accept, req_signed, req_rem, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] op_a, op_b, min_neg, special_raw, special_res;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_raw, fix_res;

    logic            core_en, core_done;
    logic [XLEN-1:0] core_quo, core_rem;

    assign req_op     = div_op_e'(bus.i_div_ctrl_op);
    assign req_signed = (req_op == OpDiv) || (req_op == OpRem);
    assign req_rem    = (req_op == OpRem) || (req_op == OpRemu);
    assign accept     = (state_q == StIdle) && bus.i_div_ctrl_valid && !bus.i_div_ctrl_flush;

`ifdef RISCV_DIV_CTRL_WORD_EN
    logic req_word, word_q;

    assign req_word    = bus.i_div_ctrl_word;
    assign op_a        = req_word ? ext_word(bus.i_div_ctrl_rs1[31:0], req_signed)
                                  : bus.i_div_ctrl_rs1;
    assign op_b        = req_word ? ext_word(bus.i_div_ctrl_rs2[31:0], req_signed)
                                  : bus.i_div_ctrl_rs2;
    assign min_neg     = req_word ? ext_word(32'h8000_0000, 1'b1) : MOST_NEG;
    assign special_res = req_word ? sext_word(special_raw[31:0]) : special_raw;
    assign fix_res     = word_q ? sext_word(fix_raw[31:0]) : fix_raw;

    // Word flag follows the accepted request; it only shapes the final result.
    always_ff @(posedge i_div_ctrl_clk or negedge i_div_ctrl_rstn) begin
        if (!i_div_ctrl_rstn) begin
            word_q <= 1'b0;
        end else if (accept) begin
            word_q <= req_word;
        end
    end
`else
    logic unused_word;

    assign unused_word = bus.i_div_ctrl_word;
    assign op_a        = bus.i_div_ctrl_rs1;
    assign op_b        = bus.i_div_ctrl_rs2;
    assign min_neg     = MOST_NEG;
    assign special_res = special_raw;
    assign fix_res     = fix_raw;
`endif

    // Request decode on the (possibly extended) operands.
    always_comb begin
        a_neg       = req_signed & op_a[XLEN-1];
        b_neg       = req_signed & op_b[XLEN-1];
        div_zero    = (op_b == '0);
        overflow    = req_signed && (op_a == min_neg) && (op_b == ALL_ONES);
        special_raw = div_zero ? (req_rem ? op_a : ALL_ONES) : (req_rem ? '0 : op_a);
    end

    // Sign fix-up of the captured core result.
    always_comb begin
        quo_fix = (sign_a_q ^ sign_b_q) ? negate(quo_q) : quo_q;
        rem_fix = sign_a_q ? negate(rem_q) : rem_q;
        fix_raw = ((op_q == OpRem) || (op_q == OpRemu)) ? rem_fix : quo_fix;
    end

    // Next-state and datapath load decisions.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        res_d    = res_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d     = req_op;
                    rd_d     = bus.i_div_ctrl_rd;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    if (div_zero || overflow) begin
                        res_d   = special_res;
                        state_d = StResp;
                    end else begin
                        mag_a_d = a_neg ? negate(op_a) : op_a;
                        mag_b_d = b_neg ? negate(op_b) : op_b;
                        state_d = StIssue;
                    end
                end
            end
            // The core is started even if a flush arrives here; DRAIN absorbs its done.
            StIssue: state_d = bus.i_div_ctrl_flush ? StDrain : StWait;
            StWait: begin
                if (bus.i_div_ctrl_flush) begin
                    // A flush coinciding with done has nothing left to drain.
                    state_d = core_done ? StIdle : StDrain;
                end else if (core_done) begin
                    quo_d   = core_quo;
                    rem_d   = core_rem;
                    state_d = StFix;
                end
            end
            StFix: begin
                if (bus.i_div_ctrl_flush) begin
                    state_d = StIdle;
                end else begin
                    res_d   = fix_res;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.i_div_ctrl_flush || bus.i_div_ctrl_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (core_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state and datapath registers.
    always_ff @(posedge i_div_ctrl_clk or negedge i_div_ctrl_rstn) begin
        if (!i_div_ctrl_rstn) begin
            state_q  <= StIdle;
            op_q     <= OpDiv;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            res_q    <= res_d;
        end
    end

    assign core_en = (state_q == StIssue);

    riscv_core_non_restoring #(
        .XLEN (XLEN)
    ) u_core (
        .clk       (i_div_ctrl_clk),
        .rst_n     (i_div_ctrl_rstn),
        .en        (core_en),
        .dividend  (mag_a_q),
        .divisor   (mag_b_q),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    assign bus.o_div_ctrl_ready  = (state_q == StIdle);
    assign bus.o_div_ctrl_valid  = (state_q == StResp);
    assign bus.o_div_ctrl_busy   = (state_q != StIdle);
    assign bus.o_div_ctrl_result = (state_q == StResp) ? res_q : '0;
    assign bus.o_div_ctrl_rd     = (state_q == StResp) ? rd_q : '0;

endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// Directed bench for riscv_core_div_ctrl; expectations depend on RISCV_DIV_CTRL_WORD_EN.
module tb_riscv_core_div_ctrl;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;
    localparam int NORM_LAT = 67;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_cnt   = 0;

    riscv_core_div_ctrl_if #(.XLEN(64)) bus ();

    riscv_core_div_ctrl #(.XLEN(64)) dut (
        .i_div_ctrl_clk  (clk),
        .i_div_ctrl_rstn (rstn),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts core enable cycles so special cases can be shown to bypass the core.
    always @(posedge clk) if (dut.core_en === 1'b1) en_cnt <= en_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        bus.i_div_ctrl_valid = 1'b1;
        bus.i_div_ctrl_op    = op;
        bus.i_div_ctrl_word  = word;
        bus.i_div_ctrl_rs1   = a;
        bus.i_div_ctrl_rs2   = b;
        bus.i_div_ctrl_rd    = rd;
        tick();
        bus.i_div_ctrl_valid = 1'b0;
        bus.i_div_ctrl_rs1   = '0;
        bus.i_div_ctrl_rs2   = '0;
    endtask

    // Edges after acceptance until valid, bounded at 200.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.o_div_ctrl_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        int en0;
        en0 = en_cnt;
        issue(op, word, a, b, rd);
        wait_valid(lat);
        check($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s.result", tag), bus.o_div_ctrl_result, exp);
        check($sformatf("%s.rd", tag), 64'(bus.o_div_ctrl_rd), 64'(rd));
        check($sformatf("%s.core_starts", tag), 64'(en_cnt - en0), (exp_lat == 0) ? 64'd0 : 64'd1);
        bus.i_div_ctrl_ready = 1'b1;
        tick();
        bus.i_div_ctrl_ready = 1'b0;
        check($sformatf("%s.back_idle", tag),
              {61'd0, bus.o_div_ctrl_ready, bus.o_div_ctrl_valid, bus.o_div_ctrl_busy},
              64'b100);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s.ready", tag), 64'(bus.o_div_ctrl_ready), 64'd1);
        check($sformatf("%s.valid", tag), 64'(bus.o_div_ctrl_valid), 64'd0);
        check($sformatf("%s.busy", tag), 64'(bus.o_div_ctrl_busy), 64'd0);
        check($sformatf("%s.result", tag), bus.o_div_ctrl_result, 64'd0);
        check($sformatf("%s.rd", tag), 64'(bus.o_div_ctrl_rd), 64'd0);
    endtask

    initial begin
        int        t;
        int        saw_valid;
        int        lat;
        int        en0;
        logic [63:0] exp_divw_ovf, exp_divw_neg;
        int        lat_divw_ovf;

`ifdef RISCV_DIV_CTRL_WORD_EN
        exp_divw_ovf = 64'hFFFF_FFFF_8000_0000;  // -2^31 / -1 in 32 bits
        lat_divw_ovf = 0;
        exp_divw_neg = 64'hFFFF_FFFF_FFFF_FFFF;  // -2 / 2 in 32 bits
`else
        exp_divw_ovf = 64'h0;                    // -2^31 / (2^32-1) at 64 bits
        lat_divw_ovf = NORM_LAT;
        exp_divw_neg = 64'h0000_0000_7FFF_FFFF;  // (2^32-2) / 2 at 64 bits
`endif

        rstn                 = 1'b0;
        bus.i_div_ctrl_valid = 1'b0;
        bus.i_div_ctrl_op    = DIV;
        bus.i_div_ctrl_word  = 1'b0;
        bus.i_div_ctrl_rs1   = '0;
        bus.i_div_ctrl_rs2   = '0;
        bus.i_div_ctrl_rd    = '0;
        bus.i_div_ctrl_flush = 1'b0;
        bus.i_div_ctrl_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Core path: sign fix-ups and plain unsigned.
        run_op("div_20_m3",  DIV,  1'b0, 64'd20, -64'sd3, 5'd1, -64'sd6, NORM_LAT);
        run_op("rem_20_m3",  REM,  1'b0, 64'd20, -64'sd3, 5'd2, 64'd2, NORM_LAT);
        run_op("divu_20_3",  DIVU, 1'b0, 64'd20, 64'd3,   5'd3, 64'd6, NORM_LAT);
        run_op("div_m7_2",   DIV,  1'b0, -64'sd7, 64'd2,  5'd4, -64'sd3, NORM_LAT);
        run_op("rem_m7_2",   REM,  1'b0, -64'sd7, 64'd2,  5'd5, -64'sd1, NORM_LAT);
        run_op("remu_100_7", REMU, 1'b0, 64'd100, 64'd7,  5'd6, 64'd2, NORM_LAT);

        // Divide by zero: answered without the core.
        run_op("div_by0",  DIV,  1'b0, 64'h1234, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("rem_by0",  REM,  1'b0, 64'h1234, 64'd0, 5'd8, 64'h1234, 0);
        run_op("divu_by0", DIVU, 1'b0, 64'h1234, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Signed overflow.
        run_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 5'd10,
               64'h8000_0000_0000_0000, 0);
        run_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 5'd11, 64'd0, 0);

        // W forms (ignored when the word feature is compiled out).
        run_op("divw_ovf", DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd12,
               exp_divw_ovf, lat_divw_ovf);
        run_op("divuw", DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 5'd13,
               64'h0000_0000_7FFF_FFFF, NORM_LAT);
        run_op("divw_neg", DIV, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 5'd14,
               exp_divw_neg, NORM_LAT);

        // Flush in IDLE blocks acceptance.
        en0 = en_cnt;
        bus.i_div_ctrl_flush = 1'b1;
        issue(DIVU, 1'b0, 64'd20, 64'd3, 5'd15);
        bus.i_div_ctrl_flush = 1'b0;
        check("flush_idle.busy", 64'(bus.o_div_ctrl_busy), 64'd0);
        check("flush_idle.ready", 64'(bus.o_div_ctrl_ready), 64'd1);
        tick();
        check("flush_idle.no_start", 64'(en_cnt - en0), 64'd0);

        // Flush 10 cycles into WAIT: drains the core, no result.
        issue(DIVU, 1'b0, 64'd20, 64'd3, 5'd16);
        t = 0;
        repeat (11) begin
            tick();
            t++;
        end
        bus.i_div_ctrl_flush = 1'b1;
        tick();
        t++;
        bus.i_div_ctrl_flush = 1'b0;
        check("flush_wait.drain_ready", 64'(bus.o_div_ctrl_ready), 64'd0);
        saw_valid = 0;
        while (bus.o_div_ctrl_ready !== 1'b1 && t < 300) begin
            if (bus.o_div_ctrl_valid === 1'b1) saw_valid++;
            tick();
            t++;
        end
        check("flush_wait.ready_edge", 64'(t), 64'd66);
        check("flush_wait.no_valid", 64'(saw_valid), 64'd0);
        run_op("after_flush", DIV, 1'b0, 64'd20, -64'sd3, 5'd17, -64'sd6, NORM_LAT);

        // Writeback stall: result and rd held.
        issue(DIVU, 1'b0, 64'd20, 64'd3, 5'd7);
        wait_valid(lat);
        check("hold.latency", 64'(lat), 64'(NORM_LAT));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d.valid", i), 64'(bus.o_div_ctrl_valid), 64'd1);
            check($sformatf("hold%0d.result", i), bus.o_div_ctrl_result, 64'd6);
            check($sformatf("hold%0d.rd", i), 64'(bus.o_div_ctrl_rd), 64'd7);
            tick();
        end
        bus.i_div_ctrl_ready = 1'b1;
        tick();
        bus.i_div_ctrl_ready = 1'b0;
        check("hold.released", {62'd0, bus.o_div_ctrl_ready, bus.o_div_ctrl_valid}, 64'b10);

        // Reset mid-WAIT.
        issue(DIV, 1'b0, 64'd20, -64'sd3, 5'd18);
        repeat (20) tick();
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        check("reset_mid.core_idle", 64'(dut.u_core.busy_q), 64'd0);
        tick();
        rstn = 1'b1;
        saw_valid = 0;
        repeat (80) begin
            if (bus.o_div_ctrl_valid === 1'b1) saw_valid++;
            tick();
        end
        check("reset_mid.no_result", 64'(saw_valid), 64'd0);
        run_op("after_reset", DIVU, 1'b0, 64'd100, 64'd7, 5'd19, 64'd14, NORM_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
